// File: rtl/vdp_pkg.sv
// Shared types and sizing for the VDP VRAM arbiter slice.
package vdp_pkg;

  localparam int unsigned VRAM_ADDR_W    = 14;
  localparam int unsigned VRAM_DATA_W    = 8;
  localparam int unsigned VDP_WBUF_DEPTH = 4;
  localparam int unsigned VDP_BURST_LEN  = 8;
  localparam int unsigned VDP_IDX_W      = $clog2(VDP_BURST_LEN);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_VGA_BURST,
    ST_IO_WR,
    ST_IO_RD
  } arb_state_t;

  // Return-path tag: follows each mem_re by one cycle to steer mem_rdata.
  typedef struct packed {
    logic                 valid;
    logic                 is_vga;
    logic [VDP_IDX_W-1:0] idx;
  } rd_tag_t;

endpackage

// File: rtl/vdp_wbuf.sv
// Posted CPU write buffer: small synchronous FIFO of {addr, data} entries.
module vdp_wbuf
  import vdp_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W,
  parameter int unsigned DATA_W = VRAM_DATA_W,
  parameter int unsigned DEPTH  = VDP_WBUF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  logic [ENT_W-1:0] ram [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_addr = ram[rd_ptr][ENT_W-1:DATA_W];
  assign head_data = ram[rd_ptr][DATA_W-1:0];

  // Entry storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (do_push) ram[wr_ptr] <= {push_addr, push_data};
  end

  // Pointers and occupancy; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vdp_vram_arbiter.sv
// Single VRAM port shared between display bursts and Z80 I/O traffic.
module vdp_vram_arbiter
  import vdp_pkg::*;
#(
  parameter int unsigned ADDR_W     = VRAM_ADDR_W,
  parameter int unsigned DATA_W     = VRAM_DATA_W,
  parameter int unsigned WBUF_DEPTH = VDP_WBUF_DEPTH,
  parameter int unsigned BURST_LEN  = VDP_BURST_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_base_addr,
  output logic              vga_ack,
  output logic              vga_data_valid,
  output logic [2:0]        vga_data_idx,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_done,
  input  logic              io_wr_valid,
  output logic              io_wr_ready,
  input  logic [ADDR_W-1:0] io_wr_addr,
  input  logic [DATA_W-1:0] io_wr_data,
  input  logic              io_rd_valid,
  output logic              io_rd_ready,
  input  logic [ADDR_W-1:0] io_rd_addr,
  output logic [DATA_W-1:0] io_rd_data,
  output logic              io_rd_data_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned IDX_W = $clog2(BURST_LEN);

  arb_state_t        state;
  logic [IDX_W-1:0]  burst_k;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_pending;
  logic              rd_issued;
  logic              cpu_turn;
  rd_tag_t           tag;

  logic              wbuf_full;
  logic              wbuf_empty;
  logic [ADDR_W-1:0] wbuf_head_addr;
  logic [DATA_W-1:0] wbuf_head_data;
  logic              rd_wait;
  logic              grant_vga;
  logic              grant_wr;
  logic              grant_rd;

  vdp_wbuf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (WBUF_DEPTH)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (io_wr_valid & io_wr_ready),
    .push_addr (io_wr_addr),
    .push_data (io_wr_data),
    .pop       (grant_wr),
    .head_addr (wbuf_head_addr),
    .head_data (wbuf_head_data),
    .full      (wbuf_full),
    .empty     (wbuf_empty)
  );

  assign io_wr_ready    = ~wbuf_full;
  assign io_rd_ready    = ~rd_pending;
  assign rd_wait        = rd_pending & ~rd_issued;
  assign vga_data_valid = tag.valid & tag.is_vga;
  assign vga_data_idx   = 3'(tag.idx);
  assign vga_done       = vga_data_valid & (tag.idx == VDP_IDX_W'(BURST_LEN - 1));
  assign vga_data       = vga_data_valid ? mem_rdata : '0;

  // Grant decision in IDLE: display first unless the CPU owns the fairness slot.
  always_comb begin
    grant_vga = 1'b0;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    if (state == ST_IDLE) begin
      if (!cpu_turn && vga_req) grant_vga = 1'b1;
      else if (!wbuf_empty)     grant_wr  = 1'b1;
      else if (rd_wait)         grant_rd  = 1'b1;
      else if (vga_req)         grant_vga = 1'b1;
    end
  end

  // Arbiter FSM with registered VRAM strobes, read tracking and return path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      burst_k          <= '0;
      base             <= '0;
      rd_addr          <= '0;
      rd_pending       <= 1'b0;
      rd_issued        <= 1'b0;
      cpu_turn         <= 1'b0;
      tag              <= '0;
      vga_ack          <= 1'b0;
      io_rd_data       <= '0;
      io_rd_data_valid <= 1'b0;
      mem_addr         <= '0;
      mem_re           <= 1'b0;
      mem_we           <= 1'b0;
      mem_wdata        <= '0;
    end else begin
      vga_ack          <= 1'b0;
      io_rd_data_valid <= 1'b0;
      mem_we           <= 1'b0;

      tag.valid  <= mem_re;
      tag.is_vga <= (state == ST_VGA_BURST);
      tag.idx    <= VDP_IDX_W'(burst_k);

      if (io_rd_valid && !rd_pending) begin
        rd_pending <= 1'b1;
        rd_addr    <= io_rd_addr;
      end

      if (tag.valid && !tag.is_vga) begin
        io_rd_data       <= mem_rdata;
        io_rd_data_valid <= 1'b1;
        rd_pending       <= 1'b0;
        rd_issued        <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (grant_vga) begin
            state    <= ST_VGA_BURST;
            base     <= vga_base_addr;
            burst_k  <= '0;
            mem_addr <= vga_base_addr;
            mem_re   <= 1'b1;
            vga_ack  <= 1'b1;
          end else if (grant_wr) begin
            state     <= ST_IO_WR;
            mem_we    <= 1'b1;
            mem_addr  <= wbuf_head_addr;
            mem_wdata <= wbuf_head_data;
            cpu_turn  <= 1'b0;
          end else if (grant_rd) begin
            state     <= ST_IO_RD;
            mem_re    <= 1'b1;
            mem_addr  <= rd_addr;
            rd_issued <= 1'b1;
            cpu_turn  <= 1'b0;
          end
        end
        ST_VGA_BURST: begin
          if (burst_k == IDX_W'(BURST_LEN - 1)) begin
            state    <= ST_IDLE;
            mem_re   <= 1'b0;
            cpu_turn <= ~wbuf_empty | rd_wait;
          end else begin
            burst_k  <= burst_k + 1'b1;
            mem_addr <= base + ADDR_W'(burst_k + 1'b1);
          end
        end
        ST_IO_WR: begin
          state <= ST_IDLE;
        end
        ST_IO_RD: begin
          state  <= ST_IDLE;
          mem_re <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          mem_re <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Directed bench for vdp_vram_arbiter with a 1-cycle-latency VRAM model.
module tb_vdp_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        vga_req;
  logic [13:0] vga_base_addr;
  logic        vga_ack;
  logic        vga_data_valid;
  logic [2:0]  vga_data_idx;
  logic [7:0]  vga_data;
  logic        vga_done;
  logic        io_wr_valid;
  logic        io_wr_ready;
  logic [13:0] io_wr_addr;
  logic [7:0]  io_wr_data;
  logic        io_rd_valid;
  logic        io_rd_ready;
  logic [13:0] io_rd_addr;
  logic [7:0]  io_rd_data;
  logic        io_rd_data_valid;
  logic [13:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int errors = 0;
  int checks = 0;
  int both_hi = 0;

  always #5 clk = ~clk;

  vdp_vram_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .vga_req          (vga_req),
    .vga_base_addr    (vga_base_addr),
    .vga_ack          (vga_ack),
    .vga_data_valid   (vga_data_valid),
    .vga_data_idx     (vga_data_idx),
    .vga_data         (vga_data),
    .vga_done         (vga_done),
    .io_wr_valid      (io_wr_valid),
    .io_wr_ready      (io_wr_ready),
    .io_wr_addr       (io_wr_addr),
    .io_wr_data       (io_wr_data),
    .io_rd_valid      (io_rd_valid),
    .io_rd_ready      (io_rd_ready),
    .io_rd_addr       (io_rd_addr),
    .io_rd_data       (io_rd_data),
    .io_rd_data_valid (io_rd_data_valid),
    .mem_addr         (mem_addr),
    .mem_re           (mem_re),
    .mem_we           (mem_we),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata)
  );

  // VRAM model: preset contents addr[7:0]^8'h5A, 1-cycle read latency.
  logic [7:0] vram [16384];
  bit         vram_init = 1'b0;
  always @(posedge clk) begin
    if (!vram_init) begin
      for (int i = 0; i < 16384; i++) vram[i] <= 8'(i) ^ 8'h5A;
      vram_init <= 1'b1;
    end else if (mem_we) begin
      vram[mem_addr] <= mem_wdata;
    end
    if (mem_re) mem_rdata <= vram[mem_addr];
  end

  // Strobe exclusivity watch.
  always @(negedge clk) if (mem_re && mem_we) both_hi++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vga_req = 1'b0; vga_base_addr = '0;
    io_wr_valid = 1'b0; io_wr_addr = '0; io_wr_data = '0;
    io_rd_valid = 1'b0; io_rd_addr = '0;
    tick(); tick();
    checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL reset_mem_re: got %b expected 0", mem_re); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    checks++; if (vga_ack !== 1'b0) begin errors++; $display("FAIL reset_vga_ack: got %b expected 0", vga_ack); end
    checks++; if (vga_data_valid !== 1'b0) begin errors++; $display("FAIL reset_vga_valid: got %b expected 0", vga_data_valid); end
    checks++; if (vga_done !== 1'b0) begin errors++; $display("FAIL reset_vga_done: got %b expected 0", vga_done); end
    checks++; if (io_rd_data_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", io_rd_data_valid); end
    checks++; if (io_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", io_wr_ready); end
    checks++; if (io_rd_ready !== 1'b1) begin errors++; $display("FAIL reset_rd_ready: got %b expected 1", io_rd_ready); end
    checks++; if (mem_addr !== 14'h0000) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
    rst = 1'b0;
    tick();
  endtask

  // CPU write then a read of the same address offered the next cycle.
  task automatic test_write_read(input logic [13:0] addr, input logic [7:0] data);
    int we_n, rdv_n, we_c, re_c;
    logic [13:0] we_a;
    logic [7:0]  we_d, rd_val;
    we_n = 0; rdv_n = 0; we_c = -1; re_c = -1; we_a = '0; we_d = '0; rd_val = '0;
    io_wr_valid = 1'b1; io_wr_addr = addr; io_wr_data = data;
    tick();
    io_wr_valid = 1'b0; io_rd_valid = 1'b1; io_rd_addr = addr;
    tick();
    io_rd_valid = 1'b0;
    checks++; if (io_rd_ready !== 1'b0) begin errors++; $display("FAIL wr_rd_busy_ready: got %b expected 0", io_rd_ready); end
    for (int c = 0; c < 20; c++) begin
      if (mem_we) begin we_n++; we_c = c; we_a = mem_addr; we_d = mem_wdata; end
      if (mem_re) re_c = c;
      if (io_rd_data_valid) begin rdv_n++; rd_val = io_rd_data; end
      tick();
    end
    checks++; if (we_n !== 1) begin errors++; $display("FAIL wr_rd_we_count: got %0d expected 1", we_n); end
    checks++; if (we_a !== addr) begin errors++; $display("FAIL wr_rd_we_addr: got %h expected %h", we_a, addr); end
    checks++; if (we_d !== data) begin errors++; $display("FAIL wr_rd_we_data: got %h expected %h", we_d, data); end
    checks++; if ((re_c > we_c) !== 1'b1) begin errors++; $display("FAIL wr_rd_order: re cycle %0d we cycle %0d, read must follow write", re_c, we_c); end
    checks++; if (rdv_n !== 1) begin errors++; $display("FAIL wr_rd_pulses: got %0d expected 1", rdv_n); end
    checks++; if (rd_val !== data) begin errors++; $display("FAIL wr_rd_data: got %h expected %h", rd_val, data); end
    checks++; if (io_rd_ready !== 1'b1) begin errors++; $display("FAIL wr_rd_ready_after: got %b expected 1", io_rd_ready); end
  endtask

  // Burst crossing the top of VRAM; base changes after ack must be ignored.
  task automatic test_burst_wrap();
    logic [13:0] exp_addr [8];
    logic [7:0]  exp_data [8];
    logic [13:0] re_addr [8];
    int          re_cyc [8];
    logic [2:0]  dv_idx [8];
    logic [7:0]  dv_data [8];
    int re_n, dv_n, done_n, ack_n;
    logic [2:0] done_idx;
    exp_addr = '{14'h3FFC, 14'h3FFD, 14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001, 14'h0002, 14'h0003};
    exp_data = '{8'hA6, 8'hA7, 8'hA4, 8'hA5, 8'h5A, 8'h5B, 8'h58, 8'h59};
    re_n = 0; dv_n = 0; done_n = 0; ack_n = 0; done_idx = '0;
    vga_base_addr = 14'h3FFC; vga_req = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (vga_ack) begin ack_n++; vga_req = 1'b0; vga_base_addr = 14'h1111; end
      if (mem_re) begin
        if (re_n < 8) begin re_addr[re_n] = mem_addr; re_cyc[re_n] = c; end
        re_n++;
      end
      if (vga_data_valid) begin
        if (dv_n < 8) begin dv_idx[dv_n] = vga_data_idx; dv_data[dv_n] = vga_data; end
        dv_n++;
      end
      if (vga_done) begin done_n++; done_idx = vga_data_idx; end
      tick();
    end
    checks++; if (ack_n !== 1) begin errors++; $display("FAIL burst_ack_count: got %0d expected 1", ack_n); end
    checks++; if (re_n !== 8) begin errors++; $display("FAIL burst_re_count: got %0d expected 8", re_n); end
    checks++; if (dv_n !== 8) begin errors++; $display("FAIL burst_valid_count: got %0d expected 8", dv_n); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL burst_done_count: got %0d expected 1", done_n); end
    checks++; if (done_idx !== 3'd7) begin errors++; $display("FAIL burst_done_idx: got %0d expected 7", done_idx); end
    if (re_n == 8 && dv_n == 8) begin
      for (int k = 0; k < 8; k++) begin
        checks++; if (re_addr[k] !== exp_addr[k]) begin errors++; $display("FAIL burst_addr[%0d]: got %h expected %h", k, re_addr[k], exp_addr[k]); end
        checks++; if (re_cyc[k] !== re_cyc[0] + k) begin errors++; $display("FAIL burst_cycle[%0d]: got %0d expected %0d", k, re_cyc[k], re_cyc[0] + k); end
        checks++; if (dv_idx[k] !== 3'(k)) begin errors++; $display("FAIL burst_idx[%0d]: got %0d expected %0d", k, dv_idx[k], k); end
        checks++; if (dv_data[k] !== exp_data[k]) begin errors++; $display("FAIL burst_data[%0d]: got %h expected %h", k, dv_data[k], exp_data[k]); end
      end
    end
  endtask

  // Display held busy while five writes stream in: one write per inter-burst slot.
  task automatic test_back_to_back();
    logic [13:0] we_addr [5];
    logic [7:0]  we_data [5];
    int          gap_re [5];
    int wr_j, we_n, re_since;
    bit will_push, full_checked;
    wr_j = 0; we_n = 0; re_since = 0; full_checked = 1'b0;
    vga_base_addr = 14'h0200; vga_req = 1'b1;
    for (int c = 0; c < 90; c++) begin
      if (mem_re) re_since++;
      if (mem_we) begin
        if (we_n < 5) begin we_addr[we_n] = mem_addr; we_data[we_n] = mem_wdata; gap_re[we_n] = re_since; end
        we_n++;
        re_since = 0;
      end
      if (wr_j == 4 && !full_checked) begin
        full_checked = 1'b1;
        checks++; if (io_wr_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b expected 0", io_wr_ready); end
      end
      if (wr_j < 5) begin
        io_wr_valid = 1'b1; io_wr_addr = 14'(16 + wr_j); io_wr_data = 8'(8'h10 + wr_j);
        will_push = io_wr_ready;
      end else begin
        io_wr_valid = 1'b0; will_push = 1'b0;
      end
      tick();
      if (will_push) wr_j++;
    end
    vga_req = 1'b0; io_wr_valid = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    checks++; if (we_n !== 5) begin errors++; $display("FAIL b2b_we_count: got %0d expected 5", we_n); end
    if (we_n == 5) begin
      for (int k = 0; k < 5; k++) begin
        checks++; if (we_addr[k] !== 14'(16 + k)) begin errors++; $display("FAIL b2b_addr[%0d]: got %h expected %h", k, we_addr[k], 14'(16 + k)); end
        checks++; if (we_data[k] !== 8'(8'h10 + k)) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, we_data[k], 8'(8'h10 + k)); end
        checks++; if (gap_re[k] !== 8) begin errors++; $display("FAIL b2b_burst_before[%0d]: got %0d reads expected 8", k, gap_re[k]); end
      end
    end
  endtask

  // Continuous display with one pending read: exactly one IO_RD between bursts.
  task automatic test_fairness_read();
    int ack_c [4];
    int ack_n, io_n, io_c, rdv_n;
    logic [7:0] rd_val;
    ack_n = 0; io_n = 0; io_c = -1; rdv_n = 0; rd_val = '0;
    vga_base_addr = 14'h0040; vga_req = 1'b1;
    io_rd_valid = 1'b1; io_rd_addr = 14'h1234;
    tick();
    io_rd_valid = 1'b0;
    for (int c = 0; c < 36; c++) begin
      if (vga_ack) begin
        if (ack_n < 4) ack_c[ack_n] = c;
        ack_n++;
      end
      if (mem_re && mem_addr == 14'h1234) begin io_n++; io_c = c; end
      if (io_rd_data_valid) begin rdv_n++; rd_val = io_rd_data; end
      tick();
    end
    vga_req = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    checks++; if (ack_n !== 4) begin errors++; $display("FAIL fair_ack_count: got %0d expected 4", ack_n); end
    checks++; if (io_n !== 1) begin errors++; $display("FAIL fair_io_count: got %0d expected 1", io_n); end
    checks++; if (rdv_n !== 1) begin errors++; $display("FAIL fair_rd_pulses: got %0d expected 1", rdv_n); end
    checks++; if (rd_val !== 8'hA5) begin errors++; $display("FAIL fair_rd_data: got %h expected a5", rd_val); end
    if (ack_n >= 3) begin
      checks++; if (io_c - ack_c[0] !== 9) begin errors++; $display("FAIL fair_io_slot: got offset %0d expected 9", io_c - ack_c[0]); end
      checks++; if (ack_c[1] - ack_c[0] !== 11) begin errors++; $display("FAIL fair_gap_with_io: got %0d expected 11", ack_c[1] - ack_c[0]); end
      checks++; if (ack_c[2] - ack_c[1] !== 9) begin errors++; $display("FAIL fair_gap_plain: got %0d expected 9", ack_c[2] - ack_c[1]); end
    end
  endtask

  // Reset at burst byte 3 with a buffered write and a pending read.
  task automatic test_reset_mid_burst();
    int done_n, dv_n, rdv_n, we_n, re_n;
    done_n = 0; dv_n = 0; rdv_n = 0; we_n = 0; re_n = 0;
    vga_base_addr = 14'h0300; vga_req = 1'b1;
    io_wr_valid = 1'b1; io_wr_addr = 14'h0500; io_wr_data = 8'h77;
    tick();
    io_wr_valid = 1'b0; io_rd_valid = 1'b1; io_rd_addr = 14'h0600;
    tick();
    io_rd_valid = 1'b0;
    tick(); tick();
    checks++; if (mem_re !== 1'b1) begin errors++; $display("FAIL midrst_k3_re: got %b expected 1", mem_re); end
    checks++; if (mem_addr !== 14'h0303) begin errors++; $display("FAIL midrst_k3_addr: got %h expected 0303", mem_addr); end
    rst = 1'b1; vga_req = 1'b0;
    tick();
    checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL midrst_re: got %b expected 0", mem_re); end
    checks++; if (vga_data_valid !== 1'b0) begin errors++; $display("FAIL midrst_vga_valid: got %b expected 0", vga_data_valid); end
    checks++; if (io_wr_ready !== 1'b1) begin errors++; $display("FAIL midrst_wr_ready: got %b expected 1", io_wr_ready); end
    checks++; if (io_rd_ready !== 1'b1) begin errors++; $display("FAIL midrst_rd_ready: got %b expected 1", io_rd_ready); end
    checks++; if (io_rd_data !== 8'h00) begin errors++; $display("FAIL midrst_rd_data: got %h expected 00", io_rd_data); end
    rst = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (vga_done) done_n++;
      if (vga_data_valid) dv_n++;
      if (io_rd_data_valid) rdv_n++;
      if (mem_we) we_n++;
      if (mem_re) re_n++;
      tick();
    end
    checks++; if (done_n !== 0) begin errors++; $display("FAIL midrst_done: got %0d expected 0", done_n); end
    checks++; if (dv_n !== 0) begin errors++; $display("FAIL midrst_vga_bytes: got %0d expected 0", dv_n); end
    checks++; if (rdv_n !== 0) begin errors++; $display("FAIL midrst_rd_pulses: got %0d expected 0", rdv_n); end
    checks++; if (we_n !== 0) begin errors++; $display("FAIL midrst_wbuf_writes: got %0d expected 0", we_n); end
    checks++; if (re_n !== 0) begin errors++; $display("FAIL midrst_reads: got %0d expected 0", re_n); end
  endtask

  task automatic test_exclusive();
    checks++; if (both_hi !== 0) begin errors++; $display("FAIL strobe_exclusive: got %0d overlapping cycles expected 0", both_hi); end
  endtask

  initial begin
    test_reset();
    test_write_read(14'h1234, 8'hA5);
    test_burst_wrap();
    test_back_to_back();
    test_write_read(14'h0100, 8'h3C);
    test_fairness_read();
    test_reset_mid_burst();
    test_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
